srx_iter32: RTL

SRX_ITER32 -- requirements
Module: srx_iter32

---
 rtl/alu_pkg.sv | 23 ++
 rtl/srx_step.sv | 19 +
 rtl/srx_iter32.sv | 109 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and sizing for the ALU shift units.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned STEP_W  = 4;
  localparam int unsigned STEP4   = 4;
  localparam int unsigned STEP8   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // In-flight shift operation: partially shifted data, remaining amount, fill bit.
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] count;
    logic               fill;
  } srx_op_t;

endpackage

// File: rtl/srx_step.sv
// One combinational right-shift step by 0..8 positions with a selectable fill bit.
module srx_step
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              fill_i,
  output logic [DATA_W-1:0] data_c_o
);

  logic [DATA_W-1:0] fill_mask_c;

  // Bits vacated at the top of the word take the fill value.
  always_comb begin
    fill_mask_c = ~({DATA_W{1'b1}} >> step_i);
    data_c_o    = (data_i >> step_i) | (fill_mask_c & {DATA_W{fill_i}});
  end

endmodule

// File: rtl/srx_iter32.sv
// Iterative 32-bit SRL/SRA unit shifting STEP bits per cycle.
// Define SRX_STEP8_EN for 8-bit steps; 4-bit steps otherwise.
module srx_iter32
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              arith,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] res
);

`ifdef SRX_STEP8_EN
  localparam int unsigned STEP = STEP8;
`else
  localparam int unsigned STEP = STEP4;
`endif

  state_e             state_q, state_d;
  srx_op_t            op_q, op_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic               busy_q, done_q;

  logic [STEP_W-1:0]  step_c;
  logic [SHAMT_W-1:0] count_left_c;
  logic [DATA_W-1:0]  shifted_c;
  logic               unused_a_c;

  // Only the instruction shamt field of a is meaningful.
  assign unused_a_c = ^{a[DATA_W-1:11], a[5:0]};

  always_comb begin
    if (op_q.count > SHAMT_W'(STEP)) begin
      step_c = STEP_W'(STEP);
    end else begin
      step_c = STEP_W'(op_q.count);
    end
    count_left_c = op_q.count - SHAMT_W'(step_c);
  end

  srx_step u_step (
    .data_i   (op_q.data),
    .step_i   (step_c),
    .fill_i   (op_q.fill),
    .data_c_o (shifted_c)
  );

  // Next-state and datapath update; flush overrides everything else.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_d.data  = b;
          op_d.count = a[10:6];
          op_d.fill  = arith & b[DATA_W-1];
          state_d    = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        op_d.data  = shifted_c;
        op_d.count = count_left_c;
        if (count_left_c == '0) begin
          res_d   = shifted_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      op_d    = op_q;
      res_d   = res_q;
    end
  end

  // Single register stage; busy/done are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      busy_q  <= (state_d == SHIFT);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;

endmodule
